loctag_panel: RTL

Parametrised user-panel front end for LocTag boards, sitting between the raw key, trigger and LED pins and the `loctag` core. It replaces the direct inversion of key pins with:
- per-key synchronisation and debouncing;
- a committed mode register with a change strobe;
- an LED sequencer that blink-codes the current mode and flashes on trigger activity.

The board top instantiates it once and drives `force_fs`/`mode` into the core from its outputs.

---
 rtl/loctag_pkg.sv | 28 ++
 rtl/loctag_panel_if.sv | 27 ++
 rtl/loctag_debounce.sv | 50 +++++
 rtl/loctag_panel.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/loctag_pkg.sv
// Shared LocTag definitions: LED blink-state encoding and default tick timing.
// Also consumed by the core's status logic.
package loctag_pkg;

  localparam logic [1:0] LED_GAP = 2'd0;
  localparam logic [1:0] LED_ON  = 2'd1;
  localparam logic [1:0] LED_OFF = 2'd2;

  typedef enum logic [1:0] {
    ST_GAP = LED_GAP,
    ST_ON  = LED_ON,
    ST_OFF = LED_OFF
  } led_state_e;

  localparam int DEF_TICK_DIV       = 50000;
  localparam int DEF_DEBOUNCE_TICKS = 20;
  localparam int DEF_ON_TICKS       = 150;
  localparam int DEF_OFF_TICKS      = 250;
  localparam int DEF_GAP_TICKS      = 1000;
  localparam int DEF_TRIG_TICKS     = 50;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/loctag_panel_if.sv
// Pin-side bundle of the LocTag user panel: raw keys and trigger in, debounced
// key state, mode and LED drive out.
interface loctag_panel_if #(
  parameter int N_KEYS = 3
);
  import loctag_pkg::*;

  logic [N_KEYS-1:0] key_n;
  logic              trig;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic              force_fs;
  logic [N_KEYS-2:0] mode;
  logic              mode_change;
  logic              led;

  modport master (
    output key_n, trig,
    input  key_level, key_press, force_fs, mode, mode_change, led
  );

  modport slave (
    input  key_n, trig,
    output key_level, key_press, force_fs, mode, mode_change, led
  );

endinterface

// File: rtl/loctag_debounce.sv
// One panel key: 2-flop synchroniser, tick-based stable counter, level and press.
// Level follows the pin after 2 cycles plus DEBOUNCE_TICKS stable ticks.
module loctag_debounce
  import loctag_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, press_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          settle;

  assign cnt_inc = cnt_q + 1'b1;
  // Accept only when this tick completes the run of disagreeing samples.
  assign settle  = tick_i && (sync2_q != level_q) && (cnt_inc == CW'(DEBOUNCE_TICKS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
      press_q <= settle & sync2_q;
      if (tick_i) begin
        if ((sync2_q == level_q) || settle) cnt_q <= '0;
        else                                cnt_q <= cnt_inc;
        if (settle) level_q <= sync2_q;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/loctag_panel.sv
// LocTag user panel: debounced keys, committed mode with change strobe, and an LED
// that blink-codes the mode and flashes on trigger. led follows trig by one cycle.
module loctag_panel
  import loctag_pkg::*;
#(
  parameter int N_KEYS         = 3,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int ON_TICKS       = DEF_ON_TICKS,
  parameter int OFF_TICKS      = DEF_OFF_TICKS,
  parameter int GAP_TICKS      = DEF_GAP_TICKS,
  parameter int TRIG_TICKS     = DEF_TRIG_TICKS
) (
  input logic           clk,
  input logic           reset,
  loctag_panel_if.slave pif
);

  localparam int MW  = N_KEYS - 1;
  localparam int TDW = $clog2(TICK_DIV + 1);
  localparam int TW  = $clog2(max3(GAP_TICKS, ON_TICKS, OFF_TICKS) + 1);
  localparam int SW  = $clog2(TRIG_TICKS + 1);

  logic [TDW-1:0]    tdiv_q;
  logic              tick;
  logic [N_KEYS-1:0] level, press;
  logic [MW-1:0]     mode_w, mode_prev_q;
  logic              mode_change_q;
  logic [SW-1:0]     stretch_q, stretch_d;
  logic              trig_act_d;
  led_state_e        state_q;
  logic [TW-1:0]     tmr_q;
  logic [MW-1:0]     cnt_q;
  logic              led_q;

  assign tick = (tdiv_q == TDW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tdiv_q <= '0;
    else       tdiv_q <= tick ? '0 : tdiv_q + 1'b1;
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    loctag_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .key_n_i (pif.key_n[k]),
      .level_o (level[k]),
      .press_o (press[k])
    );
  end

  assign mode_w = level[N_KEYS-1:1];

  // Registered compare, so keys settling on the same tick give a single pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_prev_q   <= '0;
      mode_change_q <= 1'b0;
    end else begin
      mode_prev_q   <= mode_w;
      mode_change_q <= (mode_w != mode_prev_q);
    end
  end

  always_comb begin
    stretch_d = stretch_q;
    if (pif.trig)                          stretch_d = SW'(TRIG_TICKS);
    else if (tick && (stretch_q != '0))    stretch_d = stretch_q - 1'b1;
  end

  assign trig_act_d = (stretch_d != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stretch_q <= '0;
    else       stretch_q <= stretch_d;
  end

  function automatic logic led_mix(input logic blink, input logic act, input logic ffs);
    return ffs ? ~act : (blink ^ act);
  endfunction

  // led is loaded with the value matching the state being entered, keeping it
  // aligned with the FSM and one cycle behind trig.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_GAP;
      tmr_q   <= TW'(GAP_TICKS);
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      led_q <= led_mix(state_q == ST_ON, trig_act_d, level[0]);
      if (mode_change_q) begin
        state_q <= ST_GAP;
        tmr_q   <= TW'(GAP_TICKS);
        led_q   <= led_mix(1'b0, trig_act_d, level[0]);
      end else if (tick) begin
        if (tmr_q > TW'(1)) begin
          tmr_q <= tmr_q - 1'b1;
        end else begin
          case (state_q)
            ST_GAP: begin
              state_q <= ST_ON;
              tmr_q   <= TW'(ON_TICKS);
              cnt_q   <= '0;
              led_q   <= led_mix(1'b1, trig_act_d, level[0]);
            end
            ST_ON: begin
              state_q <= ST_OFF;
              tmr_q   <= TW'(OFF_TICKS);
              led_q   <= led_mix(1'b0, trig_act_d, level[0]);
            end
            ST_OFF: begin
              if (cnt_q == mode_w) begin
                state_q <= ST_GAP;
                tmr_q   <= TW'(GAP_TICKS);
                led_q   <= led_mix(1'b0, trig_act_d, level[0]);
              end else begin
                state_q <= ST_ON;
                tmr_q   <= TW'(ON_TICKS);
                cnt_q   <= cnt_q + 1'b1;
                led_q   <= led_mix(1'b1, trig_act_d, level[0]);
              end
            end
            default: begin
              state_q <= ST_GAP;
              tmr_q   <= TW'(GAP_TICKS);
            end
          endcase
        end
      end
    end
  end

  assign pif.key_level   = level;
  assign pif.key_press   = press;
  assign pif.force_fs    = level[0];
  assign pif.mode        = mode_w;
  assign pif.mode_change = mode_change_q;
  assign pif.led         = led_q;

endmodule
